// File: rtl/pipeline_pkg.sv
// Shared constants of the forward map Y = (C_MUL1*X + C_ADD1)*C_MUL2 + C_ADD2.
// The forward block and the inverse pipeline import these constants from here.
// fwd_map() is the forward map evaluated on plain integers, for use by models.
package pipeline_pkg;

  localparam int C_MUL1 = 3;
  localparam int C_ADD1 = 5;
  localparam int C_MUL2 = 2;
  localparam int C_ADD2 = 7;

  function automatic int fwd_map(input int x);
    return (x * C_MUL1 + C_ADD1) * C_MUL2 + C_ADD2;
  endfunction

endpackage

// File: rtl/pipeline_inv_if.sv
// Stream bundle around pipeline_inv.
//   in_valid/in_ready/Y                : forward-pipeline output entering the inverter
//   out_valid/out_ready/X/inv_err      : recovered value leaving the inverter
//   err_count                          : saturating inv_err transfer count
//                                        (present only with PIPE_INV_ERRCNT_EN)
// Modports: master = producer/consumer side (bench), slave = the inverter.
interface pipeline_inv_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] Y;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] X;
  logic                inv_err;
`ifdef PIPE_INV_ERRCNT_EN
  logic [15:0]         err_count;

  modport master (
    output in_valid, Y, out_ready,
    input  in_ready, out_valid, X, inv_err, err_count
  );
  modport slave (
    input  in_valid, Y, out_ready,
    output in_ready, out_valid, X, inv_err, err_count
  );
`else
  modport master (
    output in_valid, Y, out_ready,
    input  in_ready, out_valid, X, inv_err
  );
  modport slave (
    input  in_valid, Y, out_ready,
    output in_ready, out_valid, X, inv_err
  );
`endif
endinterface

// File: rtl/pipe_slice.sv
// One valid/ready register slice.
//   clk, rst_n           : clock, async active-low reset
//   valid_i/ready_o/data_i : upstream side
//   valid_o/ready_i/data_o : downstream side
// Loads whenever it is empty or its successor takes the current item, so
// bubbles collapse and a full pipe still streams one item per cycle.
module pipe_slice #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

endmodule

// File: rtl/pipeline_inv.sv
// Inverse of the forward map: X = ((Y - C_ADD2)/C_MUL2 - C_ADD1)/C_MUL1.
// Four pipe_slice stages with valid/ready backpressure; inv_err flags a Y that
// no X can produce (X is then don't-care).
//   clk, rst_n : clock, async active-low reset
//   bus        : pipeline_inv_if.slave (Y in, X/inv_err out, optional err_count)
// Optional feature macro: PIPE_INV_ERRCNT_EN adds the saturating err_count.
module pipeline_inv
  import pipeline_pkg::*;
#(
  parameter int W  = 16,
  parameter int GW = W + 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pipeline_inv_if.slave       bus
);

  localparam logic signed [GW-1:0] KAdd2 = GW'(C_ADD2);
  localparam logic signed [GW-1:0] KAdd1 = GW'(C_ADD1);
  localparam logic signed [GW-1:0] KMul1 = GW'(C_MUL1);

  // Slice payloads are {value, err}.
  logic              v1, v2, v3;
  logic              r2, r3, r4;
  logic [GW:0]       s1_in, s1_q, s2_in, s2_q, s3_in, s3_q;
  logic [W:0]        s4_in, s4_q;

  logic signed [GW-1:0] y_ext, d1_in, d1_q, d2_in, d2_q, q_in, q_rem, q_q;
  logic                 e1_q, e2_q, e3_q;
  logic                 q_ovf;

  // S1: subtract the outer offset; an odd result cannot come out of the x2 stage.
  assign y_ext = {{(GW - W){bus.Y[W-1]}}, bus.Y};
  assign d1_in = y_ext - KAdd2;
  assign s1_in = {d1_in, d1_in[0]};

  pipe_slice #(.DW(GW + 1)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (bus.in_valid),
    .ready_o (bus.in_ready),
    .data_i  (s1_in),
    .valid_o (v1),
    .ready_i (r2),
    .data_o  (s1_q)
  );

  assign d1_q = $signed(s1_q[GW:1]);
  assign e1_q = s1_q[0];

  // S2: halve (exact whenever e1 is clear) and remove the inner offset.
  assign d2_in = (d1_q >>> 1) - KAdd1;
  assign s2_in = {d2_in, e1_q};

  pipe_slice #(.DW(GW + 1)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (v1),
    .ready_o (r2),
    .data_i  (s2_in),
    .valid_o (v2),
    .ready_i (r3),
    .data_o  (s2_q)
  );

  assign d2_q = $signed(s2_q[GW:1]);
  assign e2_q = s2_q[0];

  // S3: signed divide (truncates toward zero); any remainder means not invertible.
  assign q_in  = d2_q / KMul1;
  assign q_rem = d2_q % KMul1;
  assign s3_in = {q_in, e2_q | (q_rem != '0)};

  pipe_slice #(.DW(GW + 1)) u_s3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (v2),
    .ready_o (r3),
    .data_i  (s3_in),
    .valid_o (v3),
    .ready_i (r4),
    .data_o  (s3_q)
  );

  assign q_q  = $signed(s3_q[GW:1]);
  assign e3_q = s3_q[0];

  // S4: quotient fits in W bits only if its top GW-W+1 bits are all equal.
  assign q_ovf = !((&q_q[GW-1:W-1]) || !(|q_q[GW-1:W-1]));
  assign s4_in = {q_q[W-1:0], e3_q | q_ovf};

  pipe_slice #(.DW(W + 1)) u_s4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (v3),
    .ready_o (r4),
    .data_i  (s4_in),
    .valid_o (bus.out_valid),
    .ready_i (bus.out_ready),
    .data_o  (s4_q)
  );

  assign bus.X       = $signed(s4_q[W:1]);
  assign bus.inv_err = s4_q[0];

`ifdef PIPE_INV_ERRCNT_EN
  logic [15:0] err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.inv_err && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_pipeline_inv.sv
// Directed bench for pipeline_inv: single-item latency/values, a randomly
// back-pressured stream, a full-pipe hold, and reset with items in flight.
module tb_pipeline_inv;
  import pipeline_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_inv_if #(.W(W)) bus ();

  pipeline_inv #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Send one Y into an empty pipe with out_ready=1 and check latency and result.
  task automatic single(input int y, input int exp_x, input bit exp_err, input string tag);
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.Y = W'(y);
    #1;
    check_eq({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq({tag, "_latency"}, lat, 4);
    check_eq({tag, "_err"}, bus.inv_err, exp_err);
    if (!exp_err) check_eq({tag, "_x"}, bus.X, exp_x);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_drained"}, bus.out_valid, 0);
  endtask

  typedef struct {
    int y;
    int x;
    bit err;
  } vec_t;

  initial begin
    vec_t vecs[12];
    int   sent, rcv, occ, extra;
    bit   in_acc, out_acc;
    int   hold_y[4];
    int   hold_x[4];
    bit   hold_e[4];

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.Y = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_x", bus.X, 0);
    check_eq("rst_inv_err", bus.inv_err, 0);
`ifdef PIPE_INV_ERRCNT_EN
    check_eq("rst_err_count", bus.err_count, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("rst_in_ready", bus.in_ready, 1);

    // Hand-computed vectors; the forward map always yields odd Y.
    vecs[0]  = '{23, 1, 0};         // (3+5)*2+7
    vecs[1]  = '{17, 0, 0};
    vecs[2]  = '{-1, -3, 0};        // (-9+5)*2+7
    vecs[3]  = '{22, 0, 1};         // d1=15 odd
    vecs[4]  = '{24, 0, 1};         // d1=17 odd
    vecs[5]  = '{25, 0, 1};         // d2=4, not a multiple of 3
    vecs[6]  = '{12, 0, 1};         // d1=5 odd
    vecs[7]  = '{-3, 0, 1};         // d2=-10, remainder -1
    vecs[8]  = '{32765, 5458, 0};   // largest invertible Y
    vecs[9]  = '{32767, 0, 1};      // d2=16375, not /3
    vecs[10] = '{-32767, -5464, 0}; // most negative invertible Y
    vecs[11] = '{-32768, 0, 1};     // d1 odd
    foreach (vecs[i]) single(vecs[i].y, vecs[i].x, vecs[i].err, $sformatf("vec%0d", i));

    // Stream 0..99 with random backpressure; in_ready may drop only when all
    // four stages are occupied and the consumer stalls.
    sent = 0; rcv = 0; occ = 0;
    for (int cyc = 0; cyc < 3000 && rcv < 100; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid = (sent < 100);
      bus.Y = W'(fwd_map(sent));
      #1;
      check_eq("strm_in_ready", bus.in_ready, !(occ == 4 && !bus.out_ready));
      in_acc = bus.in_valid && bus.in_ready;
      out_acc = bus.out_valid && bus.out_ready;
      if (out_acc) begin
        check_eq("strm_x", bus.X, rcv);
        check_eq("strm_err", bus.inv_err, 0);
        rcv++;
      end
      if (in_acc) sent++;
      occ = occ + int'(in_acc) - int'(out_acc);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("strm_count", rcv, 100);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) extra++;
    end
    check_eq("strm_no_dup", extra, 0);

    // Fill the pipe with the consumer stalled, hold, then release.
    hold_y = '{fwd_map(200), 22, fwd_map(-50), fwd_map(7)};
    hold_x = '{200, 0, -50, 7};
    hold_e = '{0, 1, 0, 0};
    sent = 0;
    for (int cyc = 0; cyc < 20 && sent < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.Y = W'(hold_y[sent]);
      #1;
      in_acc = bus.in_ready;
      @(posedge clk);
      if (in_acc) sent++;
    end
    check_eq("hold_filled", sent, 4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check_eq("hold_in_ready", bus.in_ready, 0);
      check_eq("hold_valid", bus.out_valid, 1);
      check_eq("hold_x", bus.X, 200);
      check_eq("hold_err", bus.inv_err, 0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      check_eq("rel_valid", bus.out_valid, 1);
      check_eq("rel_err", bus.inv_err, hold_e[k]);
      if (!hold_e[k]) check_eq("rel_x", bus.X, hold_x[k]);
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    check_eq("rel_empty", bus.out_valid, 0);

`ifdef PIPE_INV_ERRCNT_EN
    // Fresh count: three bad Ys streamed straight through.
    do_reset();
    hold_y = '{22, 24, 25, 0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.Y = W'(hold_y[k]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("errcnt_three", bus.err_count, 3);
`endif

    // Reset with three items in flight.
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.Y = W'(fwd_map(k + 40));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", bus.out_valid, 0);
    check_eq("mid_rst_x", bus.X, 0);
`ifdef PIPE_INV_ERRCNT_EN
    check_eq("mid_rst_errcnt", bus.err_count, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) extra++;
    end
    check_eq("post_rst_silent", extra, 0);
    check_eq("post_rst_in_ready", bus.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
